// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared definitions for the RAM burst controller.
//   - state_e   : controller state; the encoding doubles as the mode output
//                 (000 INIT, 001 IRQ, 010 IDLE, 011 READ, 100 WRITE).
//   - row_of / col_of : split a {row,col} address into its fields.
//   - addr_inc  : advance a {row,col} address by one word. Column overflow
//                 carries into the row because the column sits in the low bits.
//   - addr_is_last : true at {max row, max col}, where no further word exists.
// The helpers work on 32-bit containers; callers cast to their field widths.
package ram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'b000,
    ST_IRQ   = 3'b001,
    ST_IDLE  = 3'b010,
    ST_READ  = 3'b011,
    ST_WRITE = 3'b100
  } state_e;

  function automatic logic [31:0] row_of(input logic [31:0] a, input int unsigned col_w);
    return a >> col_w;
  endfunction

  function automatic logic [31:0] col_of(input logic [31:0] a, input int unsigned col_w);
    return a & ((32'd1 << col_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_inc(input logic [31:0] a);
    return a + 32'd1;
  endfunction

  function automatic logic addr_is_last(input logic [31:0] a, input int unsigned addr_w);
    return a == ((32'd1 << addr_w) - 32'd1);
  endfunction

endpackage

// File: rtl/ram_burst_ctrl_if.sv
// ram_burst_ctrl_if: host-side request/data bus of the RAM burst controller.
//   master (host)       drives req, rw, addr, burst_len, wdata, irq_req;
//                       receives wdata_ack, rdata, rdata_vld, ready, error, mode.
//   slave (controller)  the mirror image.
interface ram_burst_ctrl_if #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 16,
  parameter int BURST_W = 4
);
  logic               req;
  logic               rw;
  logic [ADDR_W-1:0]  addr;
  logic [BURST_W-1:0] burst_len;
  logic [DATA_W-1:0]  wdata;
  logic               wdata_ack;
  logic [DATA_W-1:0]  rdata;
  logic               rdata_vld;
  logic               irq_req;
  logic               ready;
  logic               error;
  logic [2:0]         mode;

  modport master (
    output req, rw, addr, burst_len, wdata, irq_req,
    input  wdata_ack, rdata, rdata_vld, ready, error, mode
  );

  modport slave (
    input  req, rw, addr, burst_len, wdata, irq_req,
    output wdata_ack, rdata, rdata_vld, ready, error, mode
  );
endinterface

// File: rtl/ram_dq_buffer.sv
// ram_dq_buffer: write-word register and tri-state driver for the RAM data bus.
//   clk, reset  clock / asynchronous active-low reset
//   load_i      capture wdata_i into the write-word register
//   wdata_i     word from the host
//   drive_i     1 = drive dq_io from the register, 0 = release (Z)
//   sample_o    current value seen on the bus (read path)
//   dq_io       RAM data bus
module ram_dq_buffer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              drive_i,
  output logic [DATA_W-1:0] sample_o,
  inout  wire  [DATA_W-1:0] dq_io
);
  logic [DATA_W-1:0] word_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) word_q <= '0;
    else if (load_i) word_q <= wdata_i;
  end

  assign dq_io    = drive_i ? word_q : {DATA_W{1'bz}};
  assign sample_o = dq_io;
endmodule

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: burst access controller for the external frame RAM.
// Ports:
//   clk, reset            clock / asynchronous active-low reset
//   host                  ram_burst_ctrl_if.slave (request, data, status, irq)
//   mem_row, mem_col      RAM row / column address of the current word
//   mem_cs_n/we_n/oe_n    RAM strobes, active-low
//   mem_dq                RAM data bus (driven only during write words)
// Optional build macro RAM_CTRL_IRQ_RESUME_EN: when defined, an interrupted
// burst is resumed after irq_req drops; otherwise its remainder is dropped
// and error is raised.
// The write word is captured at the edge that starts its word, so the bus
// carries registered data for every cycle of the word; wdata_ack marks that
// first cycle and the host moves to the next word on the cycle after it.
module ram_burst_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int ROW_W         = 7,
  parameter int COL_W         = 9,
  parameter int BURST_W       = 4,
  parameter int INIT_CYCLES   = 16,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  ram_burst_ctrl_if.slave    host,
  output logic [ROW_W-1:0]   mem_row,
  output logic [COL_W-1:0]   mem_col,
  output logic               mem_cs_n,
  output logic               mem_we_n,
  output logic               mem_oe_n,
  inout  wire  [DATA_W-1:0]  mem_dq
);
  localparam int ADDR_W = ROW_W + COL_W;
  localparam int BEAT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(ACCESS_CYCLES - 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [INIT_W-1:0]   init_q, init_d;
  logic [BURST_W-1:0]  left_q, left_d;    // words still to do after the current one
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rw_q, rw_d;
  logic                error_q, error_d;
  logic                pend_q, pend_d;    // an interrupted burst is waiting to resume
  logic                ack_q, ack_d;
  logic                rvld_q, rvld_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                load_word;
  logic                dq_drive;
  logic [DATA_W-1:0]   dq_sample;
  logic [ADDR_W-1:0]   addr_next;

  assign addr_next = ADDR_W'(addr_inc(32'(addr_q)));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
      beat_q  <= '0;
      init_q  <= '0;
      left_q  <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      error_q <= 1'b0;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
      rvld_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      init_q  <= init_d;
      left_q  <= left_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      error_q <= error_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
      rvld_q  <= rvld_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    init_d    = init_q;
    left_d    = left_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    error_d   = error_q;
    pend_d    = pend_q;
    rdata_d   = rdata_q;
    rvld_d    = 1'b0;
    load_word = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        if (init_q == INIT_LAST) state_d = ST_IDLE;
        else init_d = init_q + INIT_W'(1);
      end
      ST_IDLE: begin
        if (host.irq_req) begin
          state_d = ST_IRQ;
        end else if (host.req) begin
          addr_d    = host.addr;
          rw_d      = host.rw;
          left_d    = host.burst_len;
          error_d   = 1'b0;
          beat_d    = '0;
          state_d   = host.rw ? ST_READ : ST_WRITE;
          load_word = !host.rw;
        end
      end
      ST_READ, ST_WRITE: begin
        if (beat_q != BEAT_LAST) begin
          beat_d = beat_q + BEAT_W'(1);
        end else begin
          beat_d = '0;
          if (state_q == ST_READ) begin
            rdata_d = dq_sample;
            rvld_d  = 1'b1;
          end
          if (left_q == '0) begin
            state_d = ST_IDLE;
          end else if (addr_is_last(32'(addr_q), ADDR_W)) begin
            // No address left past {max row, max col}: abort the burst.
            error_d = 1'b1;
            state_d = ST_IDLE;
          end else if (host.irq_req) begin
            state_d = ST_IRQ;
`ifdef RAM_CTRL_IRQ_RESUME_EN
            pend_d = 1'b1;
            addr_d = addr_next;
            left_d = left_q - BURST_W'(1);
`else
            error_d = 1'b1;
`endif
          end else begin
            addr_d    = addr_next;
            left_d    = left_q - BURST_W'(1);
            load_word = (state_q == ST_WRITE);
          end
        end
      end
      ST_IRQ: begin
        if (!host.irq_req) begin
          if (pend_q) begin
            pend_d    = 1'b0;
            beat_d    = '0;
            state_d   = rw_q ? ST_READ : ST_WRITE;
            load_word = !rw_q;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
    ack_d = load_word;
  end

  // Output logic: strobes decode straight from state so reset releases them at once
  always_comb begin
    mem_cs_n = 1'b1;
    mem_we_n = 1'b1;
    mem_oe_n = 1'b1;
    dq_drive = 1'b0;
    unique case (state_q)
      ST_READ: begin
        mem_cs_n = 1'b0;
        mem_oe_n = 1'b0;
      end
      ST_WRITE: begin
        mem_cs_n = 1'b0;
        dq_drive = 1'b1;
        // Strobe released on the last cycle so data outlasts it by one cycle.
        mem_we_n = (beat_q == BEAT_LAST);
      end
      default: ;
    endcase
  end

  assign mem_row        = ROW_W'(row_of(32'(addr_q), COL_W));
  assign mem_col        = COL_W'(col_of(32'(addr_q), COL_W));
  assign host.ready     = (state_q == ST_IDLE);
  assign host.mode      = state_q;
  assign host.error     = error_q;
  assign host.wdata_ack = ack_q;
  assign host.rdata_vld = rvld_q;
  assign host.rdata     = rdata_q;

  ram_dq_buffer #(.DATA_W(DATA_W)) u_dq (
    .clk      (clk),
    .reset    (reset),
    .load_i   (load_word),
    .wdata_i  (host.wdata),
    .drive_i  (dq_drive),
    .sample_o (dq_sample),
    .dq_io    (mem_dq)
  );
endmodule
